// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath (fetch stage, datapath,
// hazard unit).
//   NOP_INSTR     instruction word loaded into IF/ID for a bubble
//   INSTR_W       instruction width
//   ADDR_W        address width
//   PC_INC        byte increment between sequential instructions
//   fetch_entry_t {ins, pc4} as held in the fetch queue
//   word_align    clears the byte-offset bits of an address
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] ins;
      logic [ADDR_W-1:0]  pc4;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//   imem_req_valid  fetch request valid            (fetch -> memory)
//   imem_req_ready  memory accepts the request     (memory -> fetch)
//   imem_req_addr   word-aligned fetch address     (fetch -> memory)
//   imem_rsp_valid  response word valid, in order  (memory -> fetch)
//   imem_rsp_data   instruction word               (memory -> fetch)
// master = fetch stage side, slave = instruction memory side.
interface fetch_stage_if;
   import mips_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched {ins, pc4} entries between the instruction
// memory response and the IF/ID register.
//   clk, rst     clock, asynchronous active-low reset
//   clear        drop every entry (redirect); wins over push/pop
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   head         current head entry
//   count        number of stored entries
//   empty        count == 0
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_pop;
   logic             full;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CNT_FULL);
   assign do_pop = pop & ~empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= next_ptr(wr_ptr);
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   // The issue credit in the fetch stage keeps queued + outstanding <= DEPTH,
   // so a response can never find the queue full without a pop in flight.
   assert property (@(posedge clk) disable iff (!rst) !(push && full && !do_pop && !clear));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register of the pipelined MIPS
// datapath. Owns the PC, issues word reads over a valid/ready request port,
// takes in-order responses, buffers them in fetch_fifo and loads IF/ID under
// hazard-unit control (pcwrite, if_write) with branch redirect/flush.
//   clk, rst       clock, asynchronous active-low reset (0 = reset)
//   pcwrite        1 = may issue fetches / advance PC
//   if_write       1 = IF/ID may load, 0 = hold
//   branch_taken   redirect pulse; flushes IF/ID and the queue
//   branch_target  redirect address (bits [1:0] ignored)
//   imem           instruction memory port (fetch_stage_if.master)
//   pc             current fetch PC
//   if_id_ins      instruction to decode (NOP when not valid)
//   if_id_pc4      fetch address + 4 of if_id_ins (0 when not valid)
//   if_id_valid    0 = bubble
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt (accepted requests)
// and perf_bubble_cnt (cycles loading a bubble from an empty queue).
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pcwrite,
   input  logic               if_write,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   fetch_stage_if.master      imem,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] if_id_ins,
   output logic [ADDR_W-1:0]  if_id_pc4,
   output logic               if_id_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_bubble_cnt
`endif
);

   localparam int               CNT_W      = $clog2(DEPTH + 1);
   localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);

   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              fifo_empty;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_in;

   logic              req_valid;
   logic              accept;
   logic              rsp;
   logic              rsp_drop;
   logic              fifo_push;
   logic              fifo_pop;

   logic [ADDR_W-1:0] tag_mem [DEPTH];
   logic [PTR_W-1:0]  tag_wr;
   logic [PTR_W-1:0]  tag_rd;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit covers both reads in flight and words already queued, so every
   // response always has a queue slot.
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign req_valid   = rst & pcwrite & ~branch_taken & (credit_used < CREDIT_MAX);
   assign accept      = req_valid & imem.imem_req_ready;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc;

   // A response arriving in the redirect cycle belongs to the old path too.
   assign rsp       = imem.imem_rsp_valid;
   assign rsp_drop  = (drop_cnt != '0) | branch_taken;
   assign fifo_push = rsp & ~rsp_drop;
   assign fifo_pop  = ~branch_taken & if_write & ~fifo_empty;

   assign fifo_in.ins = imem.imem_rsp_data;
   assign fifo_in.pc4 = tag_mem[tag_rd];

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (branch_taken),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (branch_taken)  pc <= word_align(branch_target);
         else if (accept)   pc <= pc + PC_INC;

         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp);

         // Everything still in flight after this cycle is old-path.
         if (branch_taken)                 drop_cnt <= outstanding - CNT_W'(rsp);
         else if (rsp && drop_cnt != '0)   drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

   // PC-tag queue: one entry per read in flight, popped by every response
   // (kept or dropped), so it stays aligned with the memory across redirects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_wr <= '0;
         tag_rd <= '0;
      end else begin
         if (accept) tag_wr <= next_ptr(tag_wr);
         if (rsp)    tag_rd <= next_ptr(tag_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) tag_mem[tag_wr] <= pc + PC_INC;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_id_ins   <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (branch_taken) begin
         if_id_ins   <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (if_write) begin
         if (fifo_pop) begin
            if_id_ins   <= fifo_head.ins;
            if_id_pc4   <= fifo_head.pc4;
            if_id_valid <= 1'b1;
         end else begin
            if_id_ins   <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (!branch_taken && if_write && fifo_empty) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import mips_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct {
      logic        rb;     // apply a mid-run reset before this vector
      logic        pw;
      logic        iw;
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      int          lat;
      logic        ereq;   // imem_req_valid before the edge
      logic [31:0] epc;    // pc after the edge
      logic        ev;     // if_id_valid after the edge
      logic [31:0] epc4;   // if_id_pc4 after the edge (checked when ev)
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pcwrite = 1'b0;
   logic        if_write = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        rdy = 1'b0;
   logic [1:0]  lsel = 2'd0;
   logic [31:0] pc;
   logic [31:0] if_id_ins;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   int n_pass = 0;
   int n_total = 0;
   vec_t vecs[$];

   fetch_stage_if bus();

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .pcwrite       (pcwrite),
      .if_write      (if_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (bus),
      .pc            (pc),
      .if_id_ins     (if_id_ins),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: fixed latency 1..3, in order, data = addr ^ KEY,
   // forgets everything in flight on reset.
   logic [3:0]  pv;
   logic [31:0] pa [4];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[2:0], bus.imem_req_valid & bus.imem_req_ready};
         pa[0] <= bus.imem_req_addr;
         for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
      end
   end
   assign bus.imem_req_ready = rdy;
   assign bus.imem_rsp_valid = pv[lsel];
   assign bus.imem_rsp_data  = pa[lsel] ^ KEY;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h required %h", name, idx, act, exp);
   endtask

   function automatic vec_t mkv(input logic rb, input logic pw, input logic iw, input logic br,
                                input logic [31:0] tgt, input logic rdy_i, input int lat,
                                input logic ereq, input logic [31:0] epc, input logic ev,
                                input logic [31:0] epc4);
      vec_t t;
      t.rb = rb; t.pw = pw; t.iw = iw; t.br = br; t.tgt = tgt; t.rdy = rdy_i; t.lat = lat;
      t.ereq = ereq; t.epc = epc; t.ev = ev; t.epc4 = epc4;
      return t;
   endfunction

   // Called at a negedge; asserts reset mid-cycle and returns at a negedge
   // with reset released.
   task automatic do_reset(input int idx);
      rst = 1'b0;
      pcwrite = 1'b1;
      #1;
      chk("rst_pc", idx, pc, 32'h0);
      chk("rst_req_valid", idx, 32'(bus.imem_req_valid), 32'h0);
      chk("rst_valid", idx, 32'(if_id_valid), 32'h0);
      chk("rst_ins", idx, if_id_ins, 32'h0);
      chk("rst_pc4", idx, if_id_pc4, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic apply(input vec_t t, input int idx);
      pcwrite = t.pw; if_write = t.iw; branch_taken = t.br; branch_target = t.tgt;
      rdy = t.rdy; lsel = 2'(t.lat - 1);
      #1;
      chk("req_valid", idx, 32'(bus.imem_req_valid), 32'(t.ereq));
      @(posedge clk);
      #1;
      chk("pc", idx, pc, t.epc);
      chk("if_id_valid", idx, 32'(if_id_valid), 32'(t.ev));
      chk("if_id_ins", idx, if_id_ins, t.ev ? ((t.epc4 - 32'd4) ^ KEY) : 32'h0);
      if (t.ev) chk("if_id_pc4", idx, if_id_pc4, t.epc4);
      @(negedge clk);
   endtask

   task automatic cyc(input logic pw, input logic iw);
      pcwrite = pw; if_write = iw; branch_taken = 1'b0; rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // straight line, 1-cycle memory
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd4, 0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd8, 0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 0,32'd8, 1,32'd4));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd12,1,32'd8));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd16,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 0,32'd16,1,32'd12));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd20,1,32'd16));
      // if_write=0 for 3 cycles: hold, queue fills, request drops
      vecs.push_back(mkv(0,1,0,0,0,1,1, 1,32'd24,1,32'd16));
      vecs.push_back(mkv(0,1,0,0,0,1,1, 0,32'd24,1,32'd16));
      vecs.push_back(mkv(0,1,0,0,0,1,1, 0,32'd24,1,32'd16));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 0,32'd24,1,32'd20));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd28,1,32'd24));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd32,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 0,32'd32,1,32'd28));
      // ready low for 4 cycles
      vecs.push_back(mkv(0,1,1,0,0,0,1, 1,32'd32,1,32'd32));
      vecs.push_back(mkv(0,1,1,0,0,0,1, 1,32'd32,0,0));
      vecs.push_back(mkv(0,1,1,0,0,0,1, 1,32'd32,0,0));
      vecs.push_back(mkv(0,1,1,0,0,0,1, 1,32'd32,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd36,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 1,32'd40,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,1, 0,32'd40,1,32'd36));
      // pcwrite=0 drains
      vecs.push_back(mkv(0,0,1,0,0,1,1, 0,32'd40,1,32'd40));
      vecs.push_back(mkv(0,0,1,0,0,1,1, 0,32'd40,0,0));
      // 2-cycle memory: redirect to 0x40 with 2 reads in flight
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'd44,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'd48,0,0));
      vecs.push_back(mkv(0,1,1,1,32'h43,1,2, 0,32'h40,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h44,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h48,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h48,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h48,1,32'h44));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h4C,1,32'h48));
      vecs.push_back(mkv(0,1,0,0,0,1,2, 1,32'h50,1,32'h48));
      // back-to-back redirects, flush ignores if_write
      vecs.push_back(mkv(0,1,0,1,32'h100,1,2, 0,32'h100,0,0));
      vecs.push_back(mkv(0,1,1,1,32'h200,1,2, 0,32'h200,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h204,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h208,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h208,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h208,1,32'h204));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h20C,1,32'h208));
      // PC wrap at the top of the address space
      vecs.push_back(mkv(0,1,1,1,32'hFFFF_FFFE,1,2, 0,32'hFFFF_FFFC,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h0,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h4,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h4,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h4,1,32'h0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h8,1,32'h4));
      // reset with a read in flight, then restart from RESET_PC
      vecs.push_back(mkv(1,1,1,0,0,1,2, 1,32'h4,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'h8,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h8,0,0));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 0,32'h8,1,32'h4));
      vecs.push_back(mkv(0,1,1,0,0,1,2, 1,32'hC,1,32'h8));

      rst = 1'b0;
      pcwrite = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("init_pc", 0, pc, 32'h0);
      chk("init_req_valid", 0, 32'(bus.imem_req_valid), 32'h0);
      chk("init_valid", 0, 32'(if_id_valid), 32'h0);
      chk("init_ins", 0, if_id_ins, 32'h0);
      chk("init_pc4", 0, if_id_pc4, 32'h0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].rb) do_reset(i);
         apply(vecs[i], i);
      end

      // 10 accepted fetches, 3 bubble cycles after a fresh reset
      lsel = 2'd0;
      do_reset(1000);
      repeat (3) cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         repeat (3) cyc(1'b1, 1'b0);
         repeat (2) cyc(1'b0, 1'b1);
      end
      chk("perf_seq_pc", 1001, pc, 32'd40);
      chk("perf_seq_valid", 1001, 32'(if_id_valid), 32'h1);
      chk("perf_seq_pc4", 1001, if_id_pc4, 32'd40);
`ifdef FETCH_PERF_EN
      chk("perf_fetch_cnt", 1001, perf_fetch_cnt, 32'd10);
      chk("perf_bubble_cnt", 1001, perf_bubble_cnt, 32'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
